freq_period_meter: RTL and testbench

//  Parametrised successor to the single-bit on/off counter. Measures high time, low time
//  and period of an asynchronous input IN in CLK cycles, plus edge-count frequency over a

---
 rtl/freq_period_meter.sv | 177 +++++++++++++++++
 tb/tb_freq_period_meter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_period_meter.sv
// Measures high time, low time and period of an asynchronous input in CLK cycles,
// plus rising-edge frequency over a fixed gate window, with phase tracking and stall detection.
module freq_period_meter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int GATE_CYCLES = 1000,
    parameter int TIMEOUT     = 65535
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN,
    output logic [WIDTH-1:0] high_count,
    output logic [WIDTH-1:0] low_count,
    output logic [WIDTH:0]   period_count,
    output logic             meas_valid,
    output logic [WIDTH-1:0] freq_count,
    output logic             freq_valid,
    output logic             stalled
);

    localparam logic [1:0] ST_ARM  = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam int PW = $clog2(SYNC_STAGES + 1);

    localparam logic [WIDTH-1:0] TIMEOUT_V  = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [GW-1:0]    GATE_LAST  = GW'(GATE_CYCLES - 1);
    localparam logic [PW-1:0]    PRIME_DONE = PW'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   in_d_q, in_d_d;
    logic [PW-1:0]          prime_q, prime_d;
    logic [1:0]             state_q, state_d;
    logic [WIDTH-1:0]       hi_cnt_q, hi_cnt_d;
    logic [WIDTH-1:0]       lo_cnt_q, lo_cnt_d;
    logic [WIDTH-1:0]       high_count_q, high_count_d;
    logic [WIDTH-1:0]       low_count_q, low_count_d;
    logic [WIDTH:0]         period_count_q, period_count_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   stalled_q, stalled_d;
    logic [GW-1:0]          gate_cnt_q, gate_cnt_d;
    logic [WIDTH-1:0]       edge_cnt_q, edge_cnt_d;
    logic [WIDTH-1:0]       freq_count_q, freq_count_d;
    logic                   freq_valid_q, freq_valid_d;

    logic in_s;
    logic rise;
    logic fall;
    logic primed;
    logic terminal;

    assign in_s     = sync_q[SYNC_STAGES-1];
    assign rise     = in_s & ~in_d_q;
    assign fall     = ~in_s & in_d_q;
    // The chain holds reset zeros until SYNC_STAGES real samples arrive; ARM must not
    // mistake those zeros for a genuine low, or a high in progress at reset would be tracked.
    assign primed   = (prime_q == PRIME_DONE);
    assign terminal = (gate_cnt_q == GATE_LAST);

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it
        // unassigned; a missing default would infer a latch.
        sync_d         = {sync_q[SYNC_STAGES-2:0], IN};
        in_d_d         = in_s;
        prime_d        = primed ? prime_q : prime_q + 1'b1;
        state_d        = state_q;
        hi_cnt_d       = hi_cnt_q;
        lo_cnt_d       = lo_cnt_q;
        high_count_d   = high_count_q;
        low_count_d    = low_count_q;
        period_count_d = period_count_q;
        meas_valid_d   = 1'b0;
        stalled_d      = stalled_q;

        case (state_q)
            ST_ARM: begin
                if (primed && !in_s) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (rise) begin
                    state_d   = ST_HIGH;
                    hi_cnt_d  = WIDTH'(1);
                    stalled_d = 1'b0;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_d  = ST_LOW;
                    lo_cnt_d = WIDTH'(1);
                end else if (hi_cnt_q == TIMEOUT_V) begin
                    stalled_d = 1'b1;
                    state_d   = ST_ARM;
                end else begin
                    hi_cnt_d = hi_cnt_q + 1'b1;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    high_count_d   = hi_cnt_q;
                    low_count_d    = lo_cnt_q;
                    period_count_d = {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};
                    meas_valid_d   = 1'b1;
                    hi_cnt_d       = WIDTH'(1);
                    state_d        = ST_HIGH;
                end else if (lo_cnt_q == TIMEOUT_V) begin
                    stalled_d = 1'b1;
                    state_d   = ST_ARM;
                end else begin
                    lo_cnt_d = lo_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_ARM;
        endcase

        // A rise on the terminal cycle is folded into the closing window, not the next.
        gate_cnt_d   = terminal ? '0 : gate_cnt_q + 1'b1;
        freq_valid_d = terminal;
        freq_count_d = freq_count_q;
        edge_cnt_d   = edge_cnt_q;
        if (rise && edge_cnt_q != CNT_MAX) edge_cnt_d = edge_cnt_q + 1'b1;
        if (terminal) begin
            freq_count_d = edge_cnt_d;
            edge_cnt_d   = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q         <= '0;
            in_d_q         <= 1'b0;
            prime_q        <= '0;
            state_q        <= ST_ARM;
            hi_cnt_q       <= '0;
            lo_cnt_q       <= '0;
            high_count_q   <= '0;
            low_count_q    <= '0;
            period_count_q <= '0;
            meas_valid_q   <= 1'b0;
            stalled_q      <= 1'b0;
            gate_cnt_q     <= '0;
            edge_cnt_q     <= '0;
            freq_count_q   <= '0;
            freq_valid_q   <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            in_d_q         <= in_d_d;
            prime_q        <= prime_d;
            state_q        <= state_d;
            hi_cnt_q       <= hi_cnt_d;
            lo_cnt_q       <= lo_cnt_d;
            high_count_q   <= high_count_d;
            low_count_q    <= low_count_d;
            period_count_q <= period_count_d;
            meas_valid_q   <= meas_valid_d;
            stalled_q      <= stalled_d;
            gate_cnt_q     <= gate_cnt_d;
            edge_cnt_q     <= edge_cnt_d;
            freq_count_q   <= freq_count_d;
            freq_valid_q   <= freq_valid_d;
        end
    end

    assign high_count   = high_count_q;
    assign low_count    = low_count_q;
    assign period_count = period_count_q;
    assign meas_valid   = meas_valid_q;
    assign freq_count   = freq_count_q;
    assign freq_valid   = freq_valid_q;
    assign stalled      = stalled_q;

endmodule

// File: tb/tb_freq_period_meter.sv
// Self-checking bench: two parameterisations of freq_period_meter share one input and are
// compared every cycle against an event/timestamp model, plus hand-computed spot checks.
module tb_freq_period_meter;

    localparam int NI  = 2;
    localparam int A_W = 16, A_S = 2, A_G = 100, A_T = 50;
    localparam int B_W = 4,  B_S = 3, B_G = 100, B_T = 15;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic IN  = 1'b0;

    logic [A_W-1:0] a_high_count, a_low_count, a_freq_count;
    logic [A_W:0]   a_period_count;
    logic           a_meas_valid, a_freq_valid, a_stalled;
    logic [B_W-1:0] b_high_count, b_low_count, b_freq_count;
    logic [B_W:0]   b_period_count;
    logic           b_meas_valid, b_freq_valid, b_stalled;

    freq_period_meter #(.WIDTH(A_W), .SYNC_STAGES(A_S), .GATE_CYCLES(A_G), .TIMEOUT(A_T)) dut_a (
        .CLK(CLK), .RST(RST), .IN(IN),
        .high_count(a_high_count), .low_count(a_low_count), .period_count(a_period_count),
        .meas_valid(a_meas_valid), .freq_count(a_freq_count), .freq_valid(a_freq_valid),
        .stalled(a_stalled)
    );

    freq_period_meter #(.WIDTH(B_W), .SYNC_STAGES(B_S), .GATE_CYCLES(B_G), .TIMEOUT(B_T)) dut_b (
        .CLK(CLK), .RST(RST), .IN(IN),
        .high_count(b_high_count), .low_count(b_low_count), .period_count(b_period_count),
        .meas_valid(b_meas_valid), .freq_count(b_freq_count), .freq_valid(b_freq_valid),
        .stalled(b_stalled)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    int p_w[NI] = '{A_W, B_W};
    int p_s[NI] = '{A_S, B_S};
    int p_g[NI] = '{A_G, B_G};
    int p_t[NI] = '{A_T, B_T};

    bit samp[$];   // samp[i-1] = IN captured at clock edge i after reset release
    int n;         // clock edges since reset release

    bit m_sync[NI], m_track[NI];
    int t_r[NI], t_f[NI], t_last[NI], win[NI];
    int e_hi[NI], e_lo[NI], e_per[NI], e_mv[NI], e_fc[NI], e_fv[NI], e_st[NI];

    function automatic bit samp_at(input int idx);
        if (idx >= 1 && idx <= samp.size()) return samp[idx-1];
        return 1'b0;
    endfunction

    task automatic model_reset();
        samp.delete();
        n = 0;
        for (int k = 0; k < NI; k++) begin
            m_sync[k] = 0; m_track[k] = 0;
            t_r[k] = 0; t_f[k] = 0; t_last[k] = 0; win[k] = 0;
            e_hi[k] = 0; e_lo[k] = 0; e_per[k] = 0; e_mv[k] = 0;
            e_fc[k] = 0; e_fv[k] = 0; e_st[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        bit s, d, rise, fall;
        int cap;
        s    = samp_at(n - p_s[k]);
        d    = samp_at(n - p_s[k] - 1);
        rise = s & ~d;
        fall = ~s & d;
        e_mv[k] = 0;
        e_fv[k] = 0;
        if (m_track[k]) begin
            if (rise) begin
                e_hi[k]  = t_f[k] - t_r[k];
                e_lo[k]  = n - t_f[k];
                e_per[k] = n - t_r[k];
                e_mv[k]  = 1;
                t_r[k] = n; t_last[k] = n;
            end else if (fall) begin
                t_f[k] = n; t_last[k] = n;
            end else if (n - t_last[k] == p_t[k]) begin
                e_st[k] = 1; m_track[k] = 0;
            end
        end else if (m_sync[k]) begin
            if (rise) begin
                m_sync[k] = 0; m_track[k] = 1; e_st[k] = 0;
                t_r[k] = n; t_last[k] = n;
            end
        end else if (n - p_s[k] >= 1 && !s) begin
            m_sync[k] = 1;   // first genuine low seen while armed
        end
        if (rise) win[k]++;
        if (n % p_g[k] == 0) begin
            cap     = (1 << p_w[k]) - 1;
            e_fc[k] = (win[k] > cap) ? cap : win[k];
            e_fv[k] = 1;
            win[k]  = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) model_reset();
            else begin
                n = n + 1;
                samp.push_back(IN);
                for (int k = 0; k < NI; k++) model_step(k);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, n, $time);
        end
    endtask

    task automatic cmp_inst(input int k, input string tag,
                            input logic [31:0] hi, input logic [31:0] lo, input logic [31:0] per,
                            input logic [31:0] mv, input logic [31:0] fc, input logic [31:0] fv,
                            input logic [31:0] st);
        check({tag, "_high_count"},   hi,  e_hi[k]);
        check({tag, "_low_count"},    lo,  e_lo[k]);
        check({tag, "_period_count"}, per, e_per[k]);
        check({tag, "_meas_valid"},   mv,  e_mv[k]);
        check({tag, "_freq_count"},   fc,  e_fc[k]);
        check({tag, "_freq_valid"},   fv,  e_fv[k]);
        check({tag, "_stalled"},      st,  e_st[k]);
    endtask

    // Observations of dut_a used by the hand-computed checks.
    int mv_cnt = 0, mv_prev = 0, mv_last = 0, fv_first = -1;

    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                mv_cnt = 0; fv_first = -1;
            end else begin
                if (a_meas_valid === 1'b1) begin
                    mv_cnt++; mv_prev = mv_last; mv_last = n;
                end
                if (a_freq_valid === 1'b1 && fv_first < 0) fv_first = n;
            end
            cmp_inst(0, "a", a_high_count, a_low_count, a_period_count, a_meas_valid,
                     a_freq_count, a_freq_valid, a_stalled);
            cmp_inst(1, "b", b_high_count, b_low_count, b_period_count, b_meas_valid,
                     b_freq_count, b_freq_valid, b_stalled);
        end
    end

    // ---------------- stimulus ----------------
    task automatic hold(input bit v, input int cycles);
        IN = v;
        repeat (cycles) @(negedge CLK);
    endtask

    task automatic wave(input int hi, input int lo, input int periods);
        repeat (periods) begin
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    int saved;

    initial begin
        // reset state
        repeat (3) @(negedge CLK);
        #1;
        check("rst_a_high", a_high_count, 0);
        check("rst_a_period", a_period_count, 0);
        check("rst_b_freq", b_freq_count, 0);
        check("rst_a_stalled", a_stalled, 0);
        @(negedge CLK);
        RST = 1'b0;

        // 3 high / 5 low square wave
        wave(3, 5, 8);
        #1;
        check("t1_a_high", a_high_count, 3);
        check("t1_a_low", a_low_count, 5);
        check("t1_a_period", a_period_count, 8);
        check("t1_a_stalled", a_stalled, 0);
        check("t1_mv_spacing", mv_last - mv_prev, 8);
        check("t1_b_period", b_period_count, 8);

        // period 10 against a 100-cycle gate
        wave(5, 5, 35);
        #1;
        check("t2_a_freq", a_freq_count, 10);
        check("t2_b_freq", b_freq_count, 10);
        check("t2_first_fv_edge", fv_first, 100);
        check("t2_a_period", a_period_count, 10);

        // IN already high at reset: the partial high must be discarded
        IN = 1'b1; RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        hold(1'b1, 20);
        #1;
        check("t3_no_meas", mv_cnt, 0);
        check("t3_a_high", a_high_count, 0);
        repeat (6) begin
            hold(1'b0, 4);
            hold(1'b1, 4);
        end
        #1;
        check("t3_a_high4", a_high_count, 4);
        check("t3_a_low4", a_low_count, 4);
        check("t3_a_period8", a_period_count, 8);
        check("t3_meas_count", mv_cnt, 5);

        // long low phase stalls; outputs keep the last good 6/2 period
        wave(6, 2, 4);
        hold(1'b0, 60);
        #1;
        check("t4_a_stalled", a_stalled, 1);
        check("t4_b_stalled", b_stalled, 1);
        check("t4_a_high_hold", a_high_count, 6);
        check("t4_a_low_hold", a_low_count, 2);
        saved = mv_cnt;
        wave(3, 5, 1);
        #1;
        check("t4_a_unstall", a_stalled, 0);
        check("t4_no_meas_yet", mv_cnt, saved);
        wave(3, 5, 3);
        #1;
        check("t4_meas_resumed", mv_cnt, saved + 3);
        check("t4_a_high3", a_high_count, 3);
        check("t4_a_period8", a_period_count, 8);

        // period 4: 25 rises per window, WIDTH=4 instance saturates
        wave(2, 2, 80);
        #1;
        check("t5_a_freq", a_freq_count, 25);
        check("t5_b_freq_sat", b_freq_count, 15);
        check("t5_a_high2", a_high_count, 2);
        check("t5_b_period4", b_period_count, 4);

        // reset pulsed mid low phase
        wave(3, 5, 3);
        hold(1'b1, 3);
        hold(1'b0, 2);
        #2 RST = 1'b1;
        #1;
        check("t6_a_high_clr", a_high_count, 0);
        check("t6_a_period_clr", a_period_count, 0);
        check("t6_a_freq_clr", a_freq_count, 0);
        check("t6_b_low_clr", b_low_count, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        hold(1'b0, 4);
        wave(3, 5, 4);
        #1;
        check("t6_meas_count", mv_cnt, 3);
        check("t6_a_high", a_high_count, 3);
        check("t6_a_low", a_low_count, 5);
        check("t6_a_period", a_period_count, 8);

        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
